// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release sequencer with soft-reset entry
//
// Releases three reset domains in a fixed order after the reset pin is
// deasserted: core first, then peripheral, then the external device pin.
// A soft request while running reasserts everything and reruns the sequence.
//
// Parameters:
//   SYNC_STAGES - depth of the reset-release synchronizer (>= 2)
//   HOLD_CYCLES - cycles after synchronized release before rst_core drops (>= 1)
//   STAGE_GAP   - cycles between successive stage releases (>= 1)
//   SOFT_MIN    - minimum cycles a soft reset holds all outputs asserted (>= 1)
//
// Ports:
//   clk        - clock
//   reset_pin  - asynchronous active-high reset
//   soft_req   - synchronous level-sensitive soft-reset request
//   rst_core   - core-domain reset, active-high, registered
//   rst_periph - peripheral-domain reset, active-high, registered
//   rst_ext    - external-device reset drive, active-high, registered
//   ready      - high only when all three resets are released, registered
//   cause      - sticky last reset source: 01 = pin, 10 = soft
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int SOFT_MIN    = 4
) (
    input  logic       clk,
    input  logic       reset_pin,
    input  logic       soft_req,
    output logic       rst_core,
    output logic       rst_periph,
    output logic       rst_ext,
    output logic       ready,
    output logic [1:0] cause
);

    // One shared counter, wide enough for the largest interval it times.
    localparam int MAX_HG = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int MAX_V  = (MAX_HG > SOFT_MIN) ? MAX_HG : SOFT_MIN;
    localparam int CW     = $clog2(MAX_V + 1);

    // Terminal counts: the transition fires on the edge where the counter
    // would otherwise reach the full interval length.
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] SOFT_LAST = CW'(SOFT_MIN - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

    localparam logic [1:0] CAUSE_PIN  = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;

    typedef enum logic [2:0] {
        HOLD = 3'd0,
        GAP1 = 3'd1,
        GAP2 = 3'd2,
        RUN  = 3'd3,
        SOFT = 3'd4
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   synced;

    // Release synchronizer: asserts asynchronously with the pin, releases
    // only after the 0 has walked through every stage.
    always_ff @(posedge clk or posedge reset_pin) begin
        if (reset_pin) begin
            sync_ff <= '1;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign synced = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset_pin) begin
        if (reset_pin) begin
            state      <= HOLD;
            cnt        <= '0;
            rst_core   <= 1'b1;
            rst_periph <= 1'b1;
            rst_ext    <= 1'b1;
            ready      <= 1'b0;
            cause      <= CAUSE_PIN;
        end else begin
            case (state)
                // Count only once the synchronized release has arrived; the
                // counter stays at 0 while the chain still carries a 1.
                HOLD: begin
                    if (!synced) begin
                        if (cnt == HOLD_LAST) begin
                            rst_core <= 1'b0;
                            cnt      <= '0;
                            state    <= GAP1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                GAP1: begin
                    if (cnt == GAP_LAST) begin
                        rst_periph <= 1'b0;
                        cnt        <= '0;
                        state      <= GAP2;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                GAP2: begin
                    if (cnt == GAP_LAST) begin
                        rst_ext <= 1'b0;
                        ready   <= 1'b1;
                        cnt     <= '0;
                        state   <= RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RUN: begin
                    if (soft_req) begin
                        rst_core   <= 1'b1;
                        rst_periph <= 1'b1;
                        rst_ext    <= 1'b1;
                        ready      <= 1'b0;
                        cause      <= CAUSE_SOFT;
                        cnt        <= '0;
                        state      <= SOFT;
                    end
                end

                // Stay here for at least SOFT_MIN cycles and until the
                // request drops; the counter saturates so a long request
                // cannot wrap it back below the minimum.
                SOFT: begin
                    if ((cnt >= SOFT_LAST) && !soft_req) begin
                        cnt   <= '0;
                        state <= HOLD;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    rst_core   <= 1'b1;
                    rst_periph <= 1'b1;
                    rst_ext    <= 1'b1;
                    ready      <= 1'b0;
                    cnt        <= '0;
                    state      <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

    logic       clk;
    logic       reset_pin;
    logic       soft_req;
    logic       rst_core;
    logic       rst_periph;
    logic       rst_ext;
    logic       ready;
    logic [1:0] cause;

    int total;
    int bad;
    int e;

    reset_sequencer #(
        .SYNC_STAGES(2),
        .HOLD_CYCLES(16),
        .STAGE_GAP  (8),
        .SOFT_MIN   (4)
    ) dut (
        .clk       (clk),
        .reset_pin (reset_pin),
        .soft_req  (soft_req),
        .rst_core  (rst_core),
        .rst_periph(rst_periph),
        .rst_ext   (rst_ext),
        .ready     (ready),
        .cause     (cause)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Outputs packed as {rst_core, rst_periph, rst_ext, ready}.
    function automatic logic [3:0] outs();
        return {rst_core, rst_periph, rst_ext, ready};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        e = e + 1;
    endtask

    task automatic advance_to(input int target);
        while (e < target) step();
    endtask

    // Release reset_pin between edges; the next rising edge is edge 1.
    task automatic release_pin();
        @(negedge clk);
        reset_pin = 1'b0;
        e = 0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        e         = 0;
        reset_pin = 1'b1;
        soft_req  = 1'b0;

        // Power-on
        #1;
        chk("por_async_outs", outs(), 4'b1110);
        chk("por_async_cause", {2'b00, cause}, 4'b0001);
        repeat (5) step();
        chk("por_held_outs", outs(), 4'b1110);
        release_pin();
        advance_to(17);
        chk("por_e17", outs(), 4'b1110);
        advance_to(18);
        chk("por_e18_core", outs(), 4'b0110);
        advance_to(25);
        chk("por_e25", outs(), 4'b0110);
        advance_to(26);
        chk("por_e26_periph", outs(), 4'b0010);
        advance_to(33);
        chk("por_e33", outs(), 4'b0010);
        advance_to(34);
        chk("por_e34_ready", outs(), 4'b0001);
        chk("por_cause", {2'b00, cause}, 4'b0001);
        step();
        chk("run_stable", outs(), 4'b0001);

        // Short soft pulse: entry edge is e=0, exit at e=4, core falls at e=20
        @(negedge clk);
        soft_req = 1'b1;
        e = -1;
        step();
        soft_req = 1'b0;
        chk("ss_entry_outs", outs(), 4'b1110);
        chk("ss_entry_cause", {2'b00, cause}, 4'b0010);
        advance_to(3);
        chk("ss_e3_held", outs(), 4'b1110);
        advance_to(19);
        chk("ss_e19", outs(), 4'b1110);
        advance_to(20);
        chk("ss_e20_core", outs(), 4'b0110);
        advance_to(28);
        chk("ss_e28_periph", outs(), 4'b0010);
        advance_to(35);
        chk("ss_e35", outs(), 4'b0010);
        advance_to(36);
        chk("ss_e36_ready", outs(), 4'b0001);
        chk("ss_cause_sticky", {2'b00, cause}, 4'b0010);

        // Long soft request: high at edges 0..9, exit at 10, core falls at 26
        @(negedge clk);
        soft_req = 1'b1;
        e = -1;
        step();
        chk("ls_entry", outs(), 4'b1110);
        advance_to(9);
        soft_req = 1'b0;
        chk("ls_e9_held", outs(), 4'b1110);
        advance_to(25);
        chk("ls_e25", outs(), 4'b1110);
        advance_to(26);
        chk("ls_e26_core", outs(), 4'b0110);
        advance_to(34);
        chk("ls_e34_periph", outs(), 4'b0010);
        advance_to(41);
        chk("ls_e41", outs(), 4'b0010);
        advance_to(42);
        chk("ls_e42_ready", outs(), 4'b0001);

        // Pin reset from RUN, takes effect without a clock edge
        @(negedge clk);
        reset_pin = 1'b1;
        #1;
        chk("pin_run_async", outs(), 4'b1110);
        chk("pin_run_cause", {2'b00, cause}, 4'b0001);
        repeat (2) step();
        release_pin();
        advance_to(10);
        // 1 ns glitch right after edge 10 restarts the whole count
        #1 reset_pin = 1'b1;
        #1 reset_pin = 1'b0;
        e = 0;
        chk("glitch_outs", outs(), 4'b1110);
        advance_to(17);
        chk("glitch_e17", outs(), 4'b1110);
        advance_to(18);
        chk("glitch_e18_core", outs(), 4'b0110);
        // Soft request held high from GAP1 onward is ignored until RUN
        advance_to(19);
        soft_req = 1'b1;
        advance_to(26);
        chk("ign_e26_periph", outs(), 4'b0010);
        advance_to(34);
        chk("ign_e34_ready", outs(), 4'b0001);
        chk("ign_e34_cause", {2'b00, cause}, 4'b0001);
        advance_to(35);
        soft_req = 1'b0;
        chk("ign_e35_soft", outs(), 4'b1110);
        chk("ign_e35_cause", {2'b00, cause}, 4'b0010);

        // Pin reset mid-SOFT
        advance_to(37);
        reset_pin = 1'b1;
        #1;
        chk("msoft_async_outs", outs(), 4'b1110);
        chk("msoft_async_cause", {2'b00, cause}, 4'b0001);
        repeat (3) step();
        release_pin();
        advance_to(17);
        chk("msoft_e17", outs(), 4'b1110);
        advance_to(18);
        chk("msoft_e18_core", outs(), 4'b0110);
        advance_to(26);
        chk("msoft_e26_periph", outs(), 4'b0010);
        advance_to(34);
        chk("msoft_e34_ready", outs(), 4'b0001);
        chk("msoft_cause", {2'b00, cause}, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: depth of the reset-release synchronizer chain; legal values >= 2.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: count of clk cycles after synchronized release before rst_core deasserts; legal values >= 1.
REQ-003 SHALL have parameter STAGE_GAP, default 8: count of clk cycles between successive stage releases; legal values >= 1.
REQ-004 SHALL have parameter SOFT_MIN, default 4: minimum number of cycles a soft reset holds all outputs asserted; legal values >= 1.
REQ-005 SHALL have port clk, input, 1 bit: clock.
REQ-006 SHALL have port reset_pin, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port soft_req, input, 1 bit: synchronous soft-reset request, level-sensitive.
REQ-008 SHALL have port rst_core, output, 1 bit: core-domain reset, active-high, registered.
REQ-009 SHALL have port rst_periph, output, 1 bit: peripheral-domain reset, active-high, registered.
REQ-010 SHALL have port rst_ext, output, 1 bit: external-device reset pin drive, active-high, registered.
REQ-011 SHALL have port ready, output, 1 bit: high only when all three resets are released.
REQ-012 SHALL have port cause, output, 2 bits: sticky last reset source; 01 = pin, 10 = soft.

Function
REQ-013 SHALL implement states HOLD, GAP1, GAP2, RUN, SOFT, plus one cycle counter sized to the largest of HOLD_CYCLES, STAGE_GAP and SOFT_MIN.
REQ-014 SHALL, while reset_pin is high, asynchronously force state HOLD, counter 0, all synchronizer flops 1, rst_core = rst_periph = rst_ext = 1, ready = 0, cause = 01.
REQ-015 SHALL release reset_pin through a SYNC_STAGES-deep chain that shifts in 0 each clk; the synchronized signal is the last flop in the chain.
REQ-016 SHALL, in HOLD, increment the counter each cycle the synchronized signal is 0; when the counter reaches HOLD_CYCLES, the block clears rst_core, clears the counter and enters GAP1.
REQ-017 SHALL, in GAP1, clear rst_periph, clear the counter and enter GAP2 after STAGE_GAP cycles.
REQ-018 SHALL, in GAP2, clear rst_ext, set ready and enter RUN after STAGE_GAP cycles.
REQ-019 SHALL define release timing relative to edge 1, the first clk rising edge after reset_pin falls: rst_core falls at edge SYNC_STAGES+HOLD_CYCLES, rst_periph STAGE_GAP edges later, rst_ext and ready STAGE_GAP edges after that.
REQ-020 SHALL, in RUN, on an edge where soft_req = 1, set all three resets, clear ready, set cause = 10, clear the counter and enter SOFT.
REQ-021 SHALL, in SOFT, increment the counter each cycle (saturating); the block leaves SOFT only on an edge where counter >= SOFT_MIN-1 and soft_req = 0, entering HOLD with counter 0.
REQ-022 SHALL, on re-entry to HOLD from SOFT with the synchronizer already 0, rerun the full sequence: rst_core falls HOLD_CYCLES edges after the exit edge.
REQ-023 SHALL ignore soft_req in HOLD, GAP1 and GAP2.
REQ-024 SHALL give reset_pin priority over all other activity: assertion in any state, mid-count or mid-SOFT, takes effect immediately per REQ-014.
REQ-025 SHALL restart the HOLD count from 0 if reset_pin glitches high for any duration during a count.
REQ-026 SHALL keep outputs glitch-free: each is driven directly from a flop, with no combinational path from soft_req.
REQ-027 SHALL change cause only on pin assertion or soft entry, and keep it stable otherwise.

Reset
REQ-028 SHALL hold all outputs at their REQ-014 values for as long as reset_pin is high, independent of clk toggling.
REQ-029 SHALL NOT release any reset before SYNC_STAGES+HOLD_CYCLES clk edges after reset_pin falls.

Verification (defaults: SYNC_STAGES=2, HOLD_CYCLES=16, STAGE_GAP=8, SOFT_MIN=4)
REQ-030 SHALL cover power-on: reset_pin high 5 cycles then low -> rst_core falls at edge 18, rst_periph at 26, rst_ext and ready rise/fall at 34, cause = 01.
REQ-031 SHALL cover a pin glitch: reset_pin re-pulsed high for 1 ns at edge 10 -> outputs stay asserted, counting restarts, rst_core falls 18 edges after the glitch ends.
REQ-032 SHALL cover a short soft pulse: soft_req high 1 cycle in RUN -> all resets asserted next cycle, held 4 cycles, rst_core falls 16 edges after SOFT exit, cause = 10.
REQ-033 SHALL cover a long soft request: soft_req high 10 cycles -> resets stay asserted until the first edge with soft_req low, then the full re-sequence of 16/8/8 runs.
REQ-034 SHALL cover ignored soft requests: soft_req held high through GAP1 -> no effect and sequence timing unchanged; if still high at RUN entry, SOFT is entered on the next edge.
REQ-035 SHALL cover a pin reset mid-SOFT: reset_pin asserted during SOFT -> immediate async assert, cause = 01, full pin-release timing after reset_pin falls.
